// File: rtl/noc_params.sv
`default_nettype none
// ============================================================================
// Module      : noc_params (package)
// Description : Router-wide flit format and virtual-channel sizing.
// Revision    : 1.0
// ============================================================================
package noc_params;

    localparam int VC_NUM              = 4;
    localparam int VC_SIZE             = $clog2(VC_NUM);
    localparam int PAYLOAD_W           = 16;
    // Upstream credit counters initialise from this, so it must track the buffer depth.
    localparam int BUFFER_SIZE_DEFAULT = 8;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_SIZE-1:0]   vc_id;
        logic [PAYLOAD_W-1:0] data;
    } flit_t;

endpackage
`default_nettype wire

// File: rtl/vc_input_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vc_input_buffer_pkg (package)
// Description : Sizing helpers shared by the VC input buffer and its FIFOs.
// Revision    : 1.0
// ============================================================================
package vc_input_buffer_pkg;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vc_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vc_fifo_ctrl
// Description : Single-VC circular flit FIFO with count-decoded flags.
// Revision    : 1.0
// ============================================================================
module vc_fifo_ctrl
    import noc_params::*;
    import vc_input_buffer_pkg::*;
#(
    parameter  int BUFFER_SIZE        = BUFFER_SIZE_DEFAULT,
    parameter  int ALMOST_FULL_MARGIN = 1,
    localparam int c_CNT_W            = cnt_width(BUFFER_SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  flit_t              i_data,
    output flit_t              o_head,
    output logic [c_CNT_W-1:0] o_count,
    output logic               o_empty,
    output logic               o_full,
    output logic               o_almost_full,
    output logic               o_push_drop,
    output logic               o_pop_ack
);

    localparam int                 c_PTR_W    = $clog2(BUFFER_SIZE);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(BUFFER_SIZE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(BUFFER_SIZE);
    localparam logic [c_CNT_W-1:0] c_CNT_AF   = c_CNT_W'(BUFFER_SIZE - ALMOST_FULL_MARGIN);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    flit_t              r_mem [BUFFER_SIZE];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_LAST) ? '0 : ptr + c_PTR_ONE;
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_pop_ok  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head        = r_mem[r_rd_ptr];
    assign o_count       = r_count;
    assign o_empty       = w_empty;
    assign o_full        = w_full;
    assign o_almost_full = (r_count >= c_CNT_AF);
    assign o_push_drop   = i_push && !w_push_ok;
    assign o_pop_ack     = w_pop_ok;

endmodule
`default_nettype wire

// File: rtl/vc_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vc_input_buffer
// Description : Per-VC input FIFOs sharing one write and one read port,
//               with credit return and overflow/underflow pulses.
// Revision    : 1.0
// ============================================================================
module vc_input_buffer
    import noc_params::*;
    import vc_input_buffer_pkg::*;
#(
    parameter int BUFFER_SIZE        = BUFFER_SIZE_DEFAULT,
    parameter int ALMOST_FULL_MARGIN = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  flit_t                                   data_i,
    input  logic                                    write_i,
    input  logic                                    read_i,
    input  logic [VC_SIZE-1:0]                      read_vc_i,
    output flit_t                                   data_o,
    output logic [VC_NUM-1:0]                       is_empty_o,
    output logic [VC_NUM-1:0]                       is_full_o,
    output logic [VC_NUM-1:0]                       almost_full_o,
    output logic [VC_NUM*cnt_width(BUFFER_SIZE)-1:0] occupancy_o,
    output logic                                    credit_valid_o,
    output logic [VC_SIZE-1:0]                      credit_vc_o,
    output logic                                    overflow_o,
    output logic                                    underflow_o
);

    localparam int c_CNT_W = cnt_width(BUFFER_SIZE);

    flit_t              w_head [VC_NUM];
    logic [VC_NUM-1:0]  w_push_drop;
    logic [VC_NUM-1:0]  w_pop_ack;

    logic               r_credit_valid;
    logic [VC_SIZE-1:0] r_credit_vc;
    logic               r_overflow;
    logic               r_underflow;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        logic w_push;
        logic w_pop;

        assign w_push = write_i && (data_i.vc_id == VC_SIZE'(v));
        assign w_pop  = read_i  && (read_vc_i    == VC_SIZE'(v));

        vc_fifo_ctrl #(
            .BUFFER_SIZE        (BUFFER_SIZE),
            .ALMOST_FULL_MARGIN (ALMOST_FULL_MARGIN)
        ) u_fifo (
            .clk           (clk),
            .rst           (rst),
            .i_push        (w_push),
            .i_pop         (w_pop),
            .i_data        (data_i),
            .o_head        (w_head[v]),
            .o_count       (occupancy_o[v*c_CNT_W +: c_CNT_W]),
            .o_empty       (is_empty_o[v]),
            .o_full        (is_full_o[v]),
            .o_almost_full (almost_full_o[v]),
            .o_push_drop   (w_push_drop[v]),
            .o_pop_ack     (w_pop_ack[v])
        );
    end

    assign data_o = w_head[read_vc_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit_valid <= 1'b0;
            r_credit_vc    <= '0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_credit_valid <= |w_pop_ack;
            if (|w_pop_ack) begin
                r_credit_vc <= read_vc_i;
            end
            r_overflow  <= |w_push_drop;
            // Empty-VC reads are never bypassed, even with a same-VC write.
            r_underflow <= read_i && is_empty_o[read_vc_i];
        end
    end

    assign credit_valid_o = r_credit_valid;
    assign credit_vc_o    = r_credit_vc;
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

endmodule
`default_nettype wire
